// File: rtl/univ_ff_pkg.sv
// Shared definitions for the universal flip-flop bank: the mode encoding and
// the mode the bank comes out of reset in.
package univ_ff_pkg;

  typedef enum logic [1:0] {
    MODE_D  = 2'd0,
    MODE_T  = 2'd1,
    MODE_SR = 2'd2,
    MODE_JK = 2'd3
  } mode_e;

  localparam int unsigned MODE_W = 2;
  localparam logic [MODE_W-1:0] RST_MODE_DEFAULT = 2'd0;

endpackage

// File: rtl/univ_ff_cell.sv
// Next-state logic for one flip-flop channel. This block is purely
// combinational; the register lives in the top level.
//   mode    : current registered mode
//   q       : present state of this channel
//   a, b    : D/T/S/J and R/K inputs
//   q_nxt_c : next state (holds on the SR 11 case, never X)
//   inv_c   : SR mode with S=R=1
module univ_ff_cell
  import univ_ff_pkg::*;
(
  input  mode_e mode,
  input  logic  q,
  input  logic  a,
  input  logic  b,
  output logic  q_nxt_c,
  output logic  inv_c
);

  always_comb begin
    q_nxt_c = q;
    inv_c   = 1'b0;
    case (mode)
      MODE_D: q_nxt_c = a;
      MODE_T: q_nxt_c = q ^ a;
      MODE_SR: begin
        case ({a, b})
          2'b01:   q_nxt_c = 1'b0;
          2'b10:   q_nxt_c = 1'b1;
          2'b11:   inv_c   = 1'b1;  // state holds; flagged instead
          default: q_nxt_c = q;
        endcase
      end
      MODE_JK: begin
        case ({a, b})
          2'b01:   q_nxt_c = 1'b0;
          2'b10:   q_nxt_c = 1'b1;
          2'b11:   q_nxt_c = ~q;
          default: q_nxt_c = q;
        endcase
      end
      default: q_nxt_c = q;
    endcase
  end

endmodule

// File: rtl/univ_ff_bank.sv
// Bank of WIDTH flip-flops whose behaviour (D, T, SR, JK) is chosen at run
// time by a registered mode. SR invalid inputs hold state, set a sticky
// per-bit flag and bump a saturating per-cycle event counter.
//   clk, rst_n       : clock, async active-low reset
//   mode_in, mode_ld : new mode value and its load strobe
//   en               : update enable for q / err / err_cnt
//   a, b             : per-bit D/T/S/J and R/K inputs
//   err_clr          : clear err and err_cnt
//   q, qn            : state and its combinational inverse
//   mode             : current mode
//   err, err_cnt     : sticky invalid flags, saturating invalid-cycle count
module univ_ff_bank
  import univ_ff_pkg::*;
#(
  parameter int unsigned       WIDTH    = 8,
  parameter int unsigned       CNT_W    = 8,
  parameter logic [MODE_W-1:0] RST_MODE = RST_MODE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_in,
  input  logic              mode_ld,
  input  logic              en,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  input  logic              err_clr,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qn,
  output logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  err,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_nxt;
  logic [WIDTH-1:0] inv;
  logic [WIDTH-1:0] inv_en;
  logic             any_inv;

  // Per-bit next-state logic, all driven by the current (old) mode
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    univ_ff_cell u_cell (
      .mode    (mode_e'(mode)),
      .q       (q[i]),
      .a       (a[i]),
      .b       (b[i]),
      .q_nxt_c (q_nxt[i]),
      .inv_c   (inv[i])
    );
  end

  assign inv_en  = en ? inv : '0;
  assign any_inv = |inv_en;
  assign qn      = ~q;

  // Mode register; a load takes effect from the following edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mode <= RST_MODE;
    else if (mode_ld) mode <= mode_in;
  end

  // Flip-flop state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= q_nxt;
  end

  // Sticky flags: bits flagged on the clearing edge still get set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= '0;
    else        err <= (err_clr ? '0 : err) | inv_en;
  end

  // Saturating invalid-cycle counter; clear beats increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_cnt <= '0;
    else if (err_clr)                    err_cnt <= '0;
    else if (any_inv && err_cnt != CNT_MAX) err_cnt <= err_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_univ_ff_bank.sv
module tb_univ_ff_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_in;
  logic       mode_ld;
  logic       en;
  logic [7:0] a, b;
  logic       err_clr;

  logic [7:0] q, qn, err, err_cnt;
  logic [1:0] mode;
  logic [7:0] q2, qn2, err2;
  logic [1:0] mode2;
  logic [1:0] err_cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  univ_ff_bank #(.WIDTH(8), .CNT_W(8), .RST_MODE(2'd0)) dut (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .mode_ld(mode_ld), .en(en),
    .a(a), .b(b), .err_clr(err_clr), .q(q), .qn(qn), .mode(mode),
    .err(err), .err_cnt(err_cnt)
  );

  // Narrow-counter copy driven identically, for saturation checks
  univ_ff_bank #(.WIDTH(8), .CNT_W(2), .RST_MODE(2'd0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode_in(mode_in), .mode_ld(mode_ld), .en(en),
    .a(a), .b(b), .err_clr(err_clr), .q(q2), .qn(qn2), .mode(mode2),
    .err(err2), .err_cnt(err_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mode_in = 2'd0; mode_ld = 1'b0; en = 1'b0;
    a = 8'h00; b = 8'h00; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1; a = 8'h3C;
    step();
    en = 1'b0; a = 8'h00;
    // Assert reset between edges; state must drop without a clock edge
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (q !== 8'h00)     begin n_fail++; $display("FAIL reset_q got %h exp 00", q); end
    n_tests++; if (qn !== 8'hFF)    begin n_fail++; $display("FAIL reset_qn got %h exp FF", qn); end
    n_tests++; if (mode !== 2'd0)   begin n_fail++; $display("FAIL reset_mode got %0d exp 0", mode); end
    n_tests++; if (err !== 8'h00)   begin n_fail++; $display("FAIL reset_err got %h exp 00", err); end
    n_tests++; if (err_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt got %h exp 00", err_cnt); end
    n_tests++; if ({q2, qn2, mode2, err2, err_cnt2} !== {8'h00, 8'hFF, 2'd0, 8'h00, 2'd0})
      begin n_fail++; $display("FAIL reset_sat got %h %h %0d %h %0d", q2, qn2, mode2, err2, err_cnt2); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_d_then_t();
    en = 1'b1; a = 8'hA5;
    step();
    n_tests++; if (q !== 8'hA5) begin n_fail++; $display("FAIL d_load got %h exp A5", q); end
    n_tests++; if (qn !== 8'h5A) begin n_fail++; $display("FAIL d_qn got %h exp 5A", qn); end
    mode_in = 2'd1; mode_ld = 1'b1; a = 8'h0F;
    step();
    n_tests++; if (q !== 8'h0F) begin n_fail++; $display("FAIL d_at_mode_ld got %h exp 0F", q); end
    n_tests++; if (mode !== 2'd1) begin n_fail++; $display("FAIL mode_t got %0d exp 1", mode); end
    mode_ld = 1'b0;
    step();
    n_tests++; if (q !== 8'h00) begin n_fail++; $display("FAIL t_toggle1 got %h exp 00", q); end
    step();
    n_tests++; if (q !== 8'h0F) begin n_fail++; $display("FAIL t_toggle2 got %h exp 0F", q); end
  endtask

  task automatic test_sr_invalid();
    en = 1'b0; mode_in = 2'd2; mode_ld = 1'b1;
    step();
    n_tests++; if (mode !== 2'd2 || q !== 8'h0F)
      begin n_fail++; $display("FAIL sr_mode_ld got mode %0d q %h exp 2 0F", mode, q); end
    mode_ld = 1'b0; en = 1'b1; a = 8'h00; b = 8'hFF;
    step();
    n_tests++; if (q !== 8'h00 || err !== 8'h00)
      begin n_fail++; $display("FAIL sr_reset got q %h err %h exp 00 00", q, err); end
    a = 8'h81; b = 8'h01;
    step();
    n_tests++; if (q !== 8'h80) begin n_fail++; $display("FAIL sr_inv_q got %h exp 80", q); end
    n_tests++; if (err !== 8'h01) begin n_fail++; $display("FAIL sr_inv_err got %h exp 01", err); end
    n_tests++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL sr_inv_cnt got %0d exp 1", err_cnt); end
    for (int i = 0; i < 3; i++) step();
    n_tests++; if (err_cnt !== 8'd4) begin n_fail++; $display("FAIL sr_cnt4 got %0d exp 4", err_cnt); end
    n_tests++; if (q !== 8'h80) begin n_fail++; $display("FAIL sr_hold got %h exp 80", q); end
    n_tests++; if (err_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sr_cnt_sat got %0d exp 3", err_cnt2); end
  endtask

  task automatic test_saturation_clear();
    en = 1'b0; err_clr = 1'b1;
    step();
    n_tests++; if (err_cnt2 !== 2'd0 || err !== 8'h00 || err_cnt !== 8'd0)
      begin n_fail++; $display("FAIL clr_idle got cnt2 %0d err %h cnt %0d exp 0 00 0", err_cnt2, err, err_cnt); end
    err_clr = 1'b0; en = 1'b1; a = 8'h01; b = 8'h01;
    for (int i = 0; i < 5; i++) step();
    n_tests++; if (err_cnt2 !== 2'd3) begin n_fail++; $display("FAIL sat_cnt got %0d exp 3", err_cnt2); end
    n_tests++; if (err_cnt !== 8'd5) begin n_fail++; $display("FAIL wide_cnt got %0d exp 5", err_cnt); end
    a = 8'h04; b = 8'h04; err_clr = 1'b1;
    step();
    n_tests++; if (err_cnt2 !== 2'd0 || err_cnt !== 8'd0)
      begin n_fail++; $display("FAIL clr_wins got cnt2 %0d cnt %0d exp 0 0", err_cnt2, err_cnt); end
    n_tests++; if (err !== 8'h04) begin n_fail++; $display("FAIL clr_set_err got %h exp 04", err); end
    n_tests++; if (q !== 8'h80) begin n_fail++; $display("FAIL clr_q got %h exp 80", q); end
    err_clr = 1'b0;
  endtask

  task automatic test_jk_toggle();
    en = 1'b0; mode_in = 2'd3; mode_ld = 1'b1; a = 8'h00; b = 8'h00;
    step();
    mode_ld = 1'b0; en = 1'b1; a = 8'h0F; b = 8'hF0; err_clr = 1'b1;
    step();
    n_tests++; if (q !== 8'h0F || err !== 8'h00)
      begin n_fail++; $display("FAIL jk_set got q %h err %h exp 0F 00", q, err); end
    err_clr = 1'b0; a = 8'hFF; b = 8'hFF;
    step();
    n_tests++; if (q !== 8'hF0) begin n_fail++; $display("FAIL jk_tog1 got %h exp F0", q); end
    step();
    n_tests++; if (q !== 8'h0F) begin n_fail++; $display("FAIL jk_tog2 got %h exp 0F", q); end
    n_tests++; if (err !== 8'h00 || err_cnt !== 8'd0)
      begin n_fail++; $display("FAIL jk_noerr got err %h cnt %0d exp 00 0", err, err_cnt); end
  endtask

  task automatic test_en_hold();
    logic [1:0] exp_mode;
    logic [7:0] exp_q, exp_err, exp_cnt;
    // Create some sticky state first: SR invalid on bit 5
    mode_in = 2'd2; mode_ld = 1'b1; en = 1'b0;
    step();
    mode_ld = 1'b0; en = 1'b1; a = 8'h20; b = 8'h20;
    step();
    exp_q = 8'h0F; exp_err = 8'h20; exp_cnt = 8'd1; exp_mode = 2'd2;
    n_tests++; if (err !== exp_err || err_cnt !== exp_cnt)
      begin n_fail++; $display("FAIL hold_setup got err %h cnt %0d exp 20 1", err, err_cnt); end
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      mode_in = 2'($urandom); mode_ld = 1'($urandom);
      step();
      if (mode_ld) exp_mode = mode_in;
      n_tests++; if ({q, qn, err, err_cnt} !== {exp_q, ~exp_q, exp_err, exp_cnt})
        begin n_fail++; $display("FAIL en0_hold cyc %0d got q %h err %h cnt %0d", i, q, err, err_cnt); end
      n_tests++; if (mode !== exp_mode)
        begin n_fail++; $display("FAIL en0_mode cyc %0d got %0d exp %0d", i, mode, exp_mode); end
    end
    mode_ld = 1'b0;
  endtask

  initial begin
    test_reset();
    test_d_then_t();
    test_sr_invalid();
    test_saturation_clear();
    test_jk_toggle();
    test_en_hold();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/univ_ff_bank.md
# univ_ff_bank

Parametrised bank of WIDTH independent flip-flops whose behaviour (D, T, SR or JK) is selected at run time from a registered mode register. It generalises the team's single-bit T-from-SR conversion into one multi-bit storage primitive for control and status registers. It replaces the X-producing SR invalid case with a defined hold plus a sticky error flag and a saturating error counter.

## Interface
- WIDTH, 8: number of flip-flop channels (1..64)
- CNT_W, 8: width of saturating invalid-event counter
- RST_MODE, 2'd0: mode register value after reset (0=D, 1=T, 2=SR, 3=JK)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- mode_in  in  2  new mode value
- mode_ld  in  1  load mode_in into mode register
- en  in  1  global clock enable for the flip-flop update
- a  in  WIDTH  per-bit D / T / S / J input
- b  in  WIDTH  per-bit R / K input (ignored in D and T modes)
- err_clr  in  1  clear err and err_cnt
- q  out  WIDTH  flip-flop state
- qn  out  WIDTH  ~q, combinational
- mode  out  2  current registered mode
- err  out  WIDTH  sticky per-bit invalid-input flag
- err_cnt  out  CNT_W  saturating count of cycles with any invalid input

## Operation
- Reset (rst_n low, async): q=0, qn=all ones, mode=RST_MODE, err=0, err_cnt=0.
- Mode register: on a clk edge with mode_ld=1, mode <= mode_in. The new mode governs updates from the following edge only. The edge that loads the mode uses the old mode.
- Per-bit next state when en=1 (en=0: q holds, err/err_cnt do not update):
  - D: q <= a.
  - T: q <= q ^ a.
  - SR: 00 hold, 01 -> 0, 10 -> 1, 11 -> hold and set err[i].
  - JK: 00 hold, 01 -> 0, 10 -> 1, 11 -> toggle. Never an error.
- Invalid event: any bit with a=b=1 while mode=SR and en=1. err_cnt increments by 1 per such cycle, not per bit. It saturates at 2^CNT_W-1.
- err_clr=1 clears err and err_cnt on that edge. If an invalid event occurs on the same edge, the clear wins for the counter (result 0). err bits set by that edge's invalid bits survive (set-over-clear for err).
- No X is ever driven on q from any input combination.

## Timing
- q, err, err_cnt, mode: registered, updated one cycle after the sampled edge inputs.
- qn: zero-latency inverse of q.
- Mode change latency: 1 cycle from mode_ld to effect on q.
- Reset mid-operation: all state returns to reset values immediately, independent of clk. The first update after rst_n rises uses RST_MODE.
- mode_ld and en together: the data update uses the old mode, and the mode register updates in parallel.

## Structure
- Package univ_ff_pkg: mode enum (MODE_D, MODE_T, MODE_SR, MODE_JK) and the RST_MODE default constant.
- Sub-module univ_ff_cell: one bit's next-state logic and its invalid flag, instantiated WIDTH times via generate.
- The top level holds the mode register, the OR-reduction of invalid flags, and the saturating counter.

## Test plan
- Reset: assert rst_n=0 between edges -> q=0, qn=8'hFF, mode=0, err=0, err_cnt=0 with no clock edge.
- D then T: in D mode, a=8'hA5 with en=1 -> q=8'hA5. Then mode_ld T with a=8'h0F; at the load edge q becomes 8'h0F (D still active). With a=8'h0F on the next edge -> q=8'h00. Next edge -> q=8'h0F.
- SR invalid: mode SR, q=8'h00, a=8'h81, b=8'h01 -> q=8'h80, err=8'h01, err_cnt=1. Repeat 3 cycles -> err_cnt=4, q stays 8'h80.
- JK toggle: mode JK, q=8'h0F, a=b=8'hFF -> q=8'hF0 -> 8'h0F. err stays 0.
- Saturation and clear: CNT_W=2 with 5 invalid cycles -> err_cnt=3. err_clr together with an invalid bit 2 -> err_cnt=0, err=8'h04.
- en=0 hold: random a/b/mode for 10 cycles with en=0 -> q, err and err_cnt unchanged. Only mode follows mode_ld.
